// File: rtl/vga_sync_gen.sv
// vga_sync_gen: raster timing generator (pixel-rate divider plus h/v counters),
// beam address out to the GPU stage, and a registered colour/sync output stage.
module vga_sync_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned CLK_DIV   = 2
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic [2:0]  display_data,
  output logic [21:0] display_addr,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [2:0]  vga_rgb,
  output logic        frame_start
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VISIBLE + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VISIBLE + V_FRONT;
  localparam int unsigned DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
  localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
  localparam logic [9:0] H_ACT_FIRST = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] H_ACT_LAST  = 10'(H_SYNC + H_BACK + H_VISIBLE - 1);
  localparam logic [9:0] V_ACT_FIRST = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] V_ACT_LAST  = 10'(V_SYNC + V_BACK + V_VISIBLE - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_h_count;
  logic [9:0]       r_v_count;
  logic             r_hsync;
  logic             r_vsync;
  logic [2:0]       r_rgb;
  logic             r_frame_start;

  logic w_pix_en;
  logic w_h_wrap;
  logic w_v_wrap;
  logic w_h_active;
  logic w_v_active;
  logic w_video_active;

  assign w_pix_en       = (r_div_cnt == DIV_LAST);
  assign w_h_wrap       = (r_h_count == H_LAST);
  assign w_v_wrap       = (r_v_count == V_LAST);
  assign w_h_active     = (r_h_count >= H_ACT_FIRST) && (r_h_count <= H_ACT_LAST);
  assign w_v_active     = (r_v_count >= V_ACT_FIRST) && (r_v_count <= V_ACT_LAST);
  assign w_video_active = w_h_active && w_v_active;

  // Built only from registers and compares, so it is stable across each sysclk edge.
  assign display_addr = {w_video_active, w_pix_en, r_h_count, r_v_count};

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_pix_en) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_ONE;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_h_count <= '0;
    end else if (w_pix_en) begin
      r_h_count <= w_h_wrap ? '0 : r_h_count + 10'd1;
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_v_count <= '0;
    end else if (w_pix_en && w_h_wrap) begin
      r_v_count <= w_v_wrap ? '0 : r_v_count + 10'd1;
    end
  end

  // Colour and syncs are captured on the same pix_en edge so they leave aligned.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb   <= '0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
    end else if (w_pix_en) begin
      r_rgb   <= w_video_active ? display_data : '0;
      r_hsync <= ~(r_h_count < H_SYNC_END);
      r_vsync <= ~(r_v_count < V_SYNC_END);
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && w_h_wrap && w_v_wrap;
    end
  end

  assign vga_rgb     = r_rgb;
  assign vga_hsync   = r_hsync;
  assign vga_vsync   = r_vsync;
  assign frame_start = r_frame_start;

endmodule
